// File: rtl/nf_10g_tx_pkt_gen.sv
// rtl/nf_10g_tx_pkt_gen.sv - AXI4-Stream fixed-length test frame burst generator for the 10G s_axis port
// Optional TX_GEN_TIMESTAMP_EN stamps tuser[63:32] with a free-running cycle count.
module nf_10g_tx_pkt_gen #(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_MIN_PKT_LEN        = 60,
  parameter int C_MAX_PKT_LEN        = 9600
) (
  input  logic                              core_clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              stop,
  input  logic [15:0]                       cfg_pkt_len,
  input  logic [31:0]                       cfg_pkt_count,
  input  logic [15:0]                       cfg_ipg,
  input  logic [7:0]                        cfg_src_port,
  input  logic [7:0]                        cfg_dst_port,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  output logic                              m_axis_tlast,
  input  logic                              m_axis_tready,
  output logic                              busy,
  output logic                              done,
  output logic [31:0]                       sent_pkts,
  output logic [47:0]                       sent_bytes
);
  localparam int KEEP_W = C_M_AXIS_DATA_WIDTH / 8;
  localparam int LANES  = C_M_AXIS_DATA_WIDTH / 32;
  localparam logic [15:0] MIN_LEN = 16'(C_MIN_PKT_LEN);
  localparam logic [15:0] MAX_LEN = 16'(C_MAX_PKT_LEN);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
  state_t state, state_n;

  logic [15:0] len_l, nbeats, ipg_l, beat_idx, gap_cnt, len_clamped;
  logic [31:0] count_l, pkt_seq;
  logic [7:0]  src_l, dst_l;
  logic        stop_req, accept, last_beat, end_burst, gap_done;
  logic [4:0]  tail;
  logic [5:0]  beat_bytes;

  always_comb begin
    len_clamped = cfg_pkt_len;
    if (cfg_pkt_len < MIN_LEN)      len_clamped = MIN_LEN;
    else if (cfg_pkt_len > MAX_LEN) len_clamped = MAX_LEN;
  end

  always_ff @(posedge core_clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n       = state;
    m_axis_tvalid = (state == SEND);
    busy          = (state != IDLE);
    last_beat     = (beat_idx == nbeats - 16'd1);
    m_axis_tlast  = m_axis_tvalid && last_beat;
    accept        = m_axis_tvalid && m_axis_tready;
    end_burst     = ((count_l != 32'd0) && (pkt_seq + 32'd1 == count_l)) || stop_req;
    gap_done      = (gap_cnt == ipg_l - 16'd1);
    case (state)
      IDLE: if (start) state_n = SEND;
      SEND: begin
        if (accept && last_beat) begin
          if (end_burst)            state_n = IDLE;
          else if (ipg_l != 16'd0)  state_n = GAP;
        end
      end
      GAP: begin
        if (stop_req)      state_n = IDLE;
        else if (gap_done) state_n = SEND;
      end
      default: state_n = IDLE;
    endcase
  end

  // Bytes on the final beat come straight from the latched length, which equals popcount(tkeep).
  assign tail       = len_l[4:0];
  assign beat_bytes = (last_beat && tail != 5'd0) ? {1'b0, tail} : 6'd32;

  always_ff @(posedge core_clk) begin
    if (rst) begin
      len_l      <= '0;
      nbeats     <= '0;
      ipg_l      <= '0;
      count_l    <= '0;
      src_l      <= '0;
      dst_l      <= '0;
      beat_idx   <= '0;
      pkt_seq    <= '0;
      gap_cnt    <= '0;
      stop_req   <= 1'b0;
      done       <= 1'b0;
      sent_pkts  <= '0;
      sent_bytes <= '0;
    end else begin
      done <= 1'b0;
      if (state == IDLE && start) begin
        len_l    <= len_clamped;
        nbeats   <= (len_clamped + 16'd31) >> 5;
        ipg_l    <= cfg_ipg;
        count_l  <= cfg_pkt_count;
        src_l    <= cfg_src_port;
        dst_l    <= cfg_dst_port;
        beat_idx <= '0;
        pkt_seq  <= '0;
        stop_req <= stop;
      end else if (state != IDLE && stop) begin
        stop_req <= 1'b1;
      end
      if (accept) begin
        sent_bytes <= sent_bytes + 48'(beat_bytes);
        if (last_beat) begin
          beat_idx  <= '0;
          pkt_seq   <= pkt_seq + 32'd1;
          sent_pkts <= sent_pkts + 32'd1;
        end else begin
          beat_idx <= beat_idx + 16'd1;
        end
      end
      gap_cnt <= (state == GAP) ? gap_cnt + 16'd1 : 16'd0;
      if (state != IDLE && state_n == IDLE) begin
        stop_req <= 1'b0;
        done     <= 1'b1;
      end
    end
  end

`ifdef TX_GEN_TIMESTAMP_EN
  logic [31:0] cyc_cnt, ts_l;

  // Stamp with the count seen during the cycle the first beat is presented.
  always_ff @(posedge core_clk) begin
    if (rst) begin
      cyc_cnt <= '0;
      ts_l    <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 32'd1;
      if (state_n == SEND && (state != SEND || (accept && last_beat)))
        ts_l <= cyc_cnt + 32'd1;
    end
  end
`endif

  always_comb begin
    m_axis_tkeep = '0;
    m_axis_tdata = '0;
    m_axis_tuser = '0;
    if (m_axis_tvalid) begin
      m_axis_tkeep = '1;
      if (last_beat && tail != 5'd0)
        m_axis_tkeep = (KEEP_W'(1) << tail) - KEEP_W'(1);
      for (int k = 0; k < LANES; k++)
        m_axis_tdata[32*k +: 32] = {pkt_seq[15:0], beat_idx[12:0], 3'(k)};
      for (int j = 0; j < KEEP_W; j++)
        if (!m_axis_tkeep[j]) m_axis_tdata[8*j +: 8] = 8'h00;
      m_axis_tuser[15:0]  = len_l;
      m_axis_tuser[23:16] = src_l;
      m_axis_tuser[31:24] = dst_l;
`ifdef TX_GEN_TIMESTAMP_EN
      m_axis_tuser[63:32] = ts_l;
`endif
    end
  end
endmodule
